dma_irq_coalesce: RTL and testbench

DMA_IRQ_COALESCE -- requirements
Module: dma_irq_coalesce

---
 rtl/dma_irq_coalesce.sv | 164 ++++++++++++++++
 tb/tb_dma_irq_coalesce.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_irq_coalesce.sv
// -----------------------------------------------------------------------------
// dma_irq_coalesce
//
// Coalesces per-transfer completion pulses from an iDMA backend into a single
// level interrupt. An interrupt is raised once enough completions have
// accumulated (threshold) or, optionally, once the oldest pending completion
// has waited long enough (timeout). Software acknowledges with irq_ack_i.
//
// Optional feature:
//   DMA_IRQ_COALESCE_TIMEOUT_EN - when defined, adds the timeout timer and the
//                                 timeout fire term. When undefined, timeout_i
//                                 is ignored and only the threshold fires.
//
// Parameters:
//   CntWidth   - width of the completion counters
//   TimerWidth - width of the timeout timer and timeout_i
//
// Ports:
//   clk_i            - clock, all state changes on the rising edge
//   rst_i            - synchronous active-high reset
//   trans_complete_i - one pulse per completed transfer
//   enable_i         - permits interrupt generation
//   threshold_i      - completions per interrupt (0 behaves as 1)
//   timeout_i        - cycles from first pending completion to forced
//                      interrupt (0 disables)
//   irq_ack_i        - software acknowledge, only honoured while irq_o is high
//   irq_o            - coalesced interrupt, level, registered
//   fired_cnt_o      - completions covered by the current / last interrupt
//   pending_cnt_o    - completions not yet covered by an interrupt
//   overflow_o       - sticky: a completion arrived with pending saturated
// -----------------------------------------------------------------------------
module dma_irq_coalesce #(
  parameter int unsigned CntWidth   = 8,
  parameter int unsigned TimerWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  trans_complete_i,
  input  logic                  enable_i,
  input  logic [CntWidth-1:0]   threshold_i,
  input  logic [TimerWidth-1:0] timeout_i,
  input  logic                  irq_ack_i,
  output logic                  irq_o,
  output logic [CntWidth-1:0]   fired_cnt_o,
  output logic [CntWidth-1:0]   pending_cnt_o,
  output logic                  overflow_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,   // nothing pending
    ACCUM = 2'd1,   // completions pending, timer running
    FIRE  = 2'd2    // interrupt asserted, waiting for acknowledge
  } state_e;

  state_e              state_q;
  logic                irq_q;
  logic                overflow_q;
  logic [CntWidth-1:0] pending_q;
  logic [CntWidth-1:0] fired_q;

  // Pending count after this cycle's pulse; it saturates instead of wrapping so
  // the count never under-reports, and the lost pulse is flagged as overflow.
  logic [CntWidth-1:0] pending_d;
  logic                sat_hit;
  logic [CntWidth-1:0] thr_eff;
  logic                thr_hit;
  logic                timeout_hit;
  logic                fire;
  logic                ack_fire;

  assign sat_hit   = trans_complete_i && (pending_q == '1);
  assign pending_d = (pending_q == '1) ? pending_q
                                       : pending_q + CntWidth'(trans_complete_i);

  assign thr_eff   = (threshold_i == '0) ? CntWidth'(1) : threshold_i;
  assign thr_hit   = (pending_d >= thr_eff);

`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
  logic [TimerWidth-1:0] timer_q;

  // The timer counts cycles since the first pending completion; the pending
  // qualifier keeps a timeout of 1 from firing with nothing to report.
  assign timeout_hit = (timeout_i != '0) && (pending_d != '0) &&
                       (timer_q == timeout_i - TimerWidth'(1));
`else
  // Timeout input is intentionally unused in the threshold-only build.
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign timeout_hit    = 1'b0;
`endif

  assign fire     = enable_i && (thr_hit || timeout_hit);
  assign ack_fire = (state_q == FIRE) && irq_ack_i;

  // NOTE: every register below is assigned with <= so all of them see the
  // pre-edge values of each other, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      irq_q      <= 1'b0;
      overflow_q <= 1'b0;
      pending_q  <= '0;
      fired_q    <= '0;
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      // Acknowledge clears the sticky flag, but a saturating pulse in the same
      // cycle is a fresh event and must not be lost.
      overflow_q <= (ack_fire ? 1'b0 : overflow_q) | sat_hit;

      case (state_q)
        IDLE, ACCUM: begin
          if (fire) begin
            state_q   <= FIRE;
            irq_q     <= 1'b1;
            fired_q   <= pending_d;
            pending_q <= '0;
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
            timer_q   <= '0;
`endif
          end else begin
            pending_q <= pending_d;
            // In ACCUM pending_d is never zero, so this also keeps ACCUM.
            if (pending_d != '0) begin
              state_q <= ACCUM;
            end
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
            // Timer only runs while accumulating with interrupts enabled;
            // the cycle of the first pulse leaves it at zero.
            if ((state_q == ACCUM) && enable_i) begin
              timer_q <= (timer_q == '1) ? timer_q : timer_q + TimerWidth'(1);
            end else begin
              timer_q <= '0;
            end
`endif
          end
        end

        FIRE: begin
          pending_q <= pending_d;
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
          timer_q   <= '0;
`endif
          if (irq_ack_i) begin
            irq_q   <= 1'b0;
            state_q <= (pending_d != '0) ? ACCUM : IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_o         = irq_q;
  assign fired_cnt_o   = fired_q;
  assign pending_cnt_o = pending_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_dma_irq_coalesce.sv
// -----------------------------------------------------------------------------
// Testbench for dma_irq_coalesce (default parameters).
// A driver applies directed and random stimulus on the falling edge, steps a
// behavioural model and queues the expected outputs; a monitor compares the
// DUT outputs shortly after each rising edge against the queued expectations.
// -----------------------------------------------------------------------------
module tb_dma_irq_coalesce;

  localparam int CW   = 8;
  localparam int TW   = 16;
  localparam int CMAX = (1 << CW) - 1;
  localparam int TMAX = (1 << TW) - 1;
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          trans_complete_i = 1'b0;
  logic          enable_i = 1'b0;
  logic [CW-1:0] threshold_i = '0;
  logic [TW-1:0] timeout_i = '0;
  logic          irq_ack_i = 1'b0;
  logic          irq_o;
  logic [CW-1:0] fired_cnt_o;
  logic [CW-1:0] pending_cnt_o;
  logic          overflow_o;

  dma_irq_coalesce #(.CntWidth(CW), .TimerWidth(TW)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .trans_complete_i (trans_complete_i),
    .enable_i         (enable_i),
    .threshold_i      (threshold_i),
    .timeout_i        (timeout_i),
    .irq_ack_i        (irq_ack_i),
    .irq_o            (irq_o),
    .fired_cnt_o      (fired_cnt_o),
    .pending_cnt_o    (pending_cnt_o),
    .overflow_o       (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit irq;
    int fired;
    int pend;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  // Behavioural model: counts and an "interrupt outstanding" flag; the age of
  // the oldest pending completion stands in for the timer.
  bit m_irq = 1'b0;
  int m_fired = 0;
  int m_pend = 0;
  bit m_ovf = 1'b0;
  int m_age = 0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(bit rst, bit pulse, bit en, int thr, int tmo, bit ack);
    int pn;
    bit sat_hit;
    bit fire;
    bit to_hit;
    if (rst) begin
      m_irq = 0; m_fired = 0; m_pend = 0; m_ovf = 0; m_age = 0;
      return;
    end
    pn      = (m_pend + int'(pulse) > CMAX) ? CMAX : m_pend + int'(pulse);
    sat_hit = pulse && (m_pend == CMAX);
    if (m_irq) begin
      m_pend = pn;
      m_age  = 0;
      if (ack) begin
        m_irq = 0;
        m_ovf = sat_hit;
      end else begin
        m_ovf = m_ovf | sat_hit;
      end
    end else begin
      m_ovf  = m_ovf | sat_hit;
      to_hit = TIMEOUT_EN && (tmo != 0) && (pn > 0) && (m_age == tmo - 1);
      fire   = en && ((pn >= ((thr == 0) ? 1 : thr)) || to_hit);
      if (fire) begin
        m_irq = 1; m_fired = pn; m_pend = 0; m_age = 0;
      end else begin
        // Age starts counting the cycle after the first completion arrives.
        if (m_pend > 0 && en) m_age = (m_age == TMAX) ? TMAX : m_age + 1;
        else m_age = 0;
        m_pend = pn;
      end
    end
  endtask

  task automatic step(bit rst, bit pulse, bit en, int thr, int tmo, bit ack);
    exp_t e;
    @(negedge clk_i);
    rst_i = rst; trans_complete_i = pulse; enable_i = en;
    threshold_i = CW'(thr); timeout_i = TW'(tmo); irq_ack_i = ack;
    model_step(rst, pulse, en, thr, tmo, ack);
    e.irq = m_irq; e.fired = m_fired; e.pend = m_pend; e.ovf = m_ovf;
    exp_q.push_back(e);
  endtask

  // Wait until just after the edge that registers the last stepped inputs.
  task automatic after_edge();
    @(posedge clk_i);
    #2;
  endtask

  // Monitor: the DUT presents a new output set every cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_irq", int'(irq_o), int'(e.irq));
        check("sb_fired", int'(fired_cnt_o), e.fired);
        check("sb_pending", int'(pending_cnt_o), e.pend);
        check("sb_overflow", int'(overflow_o), int'(e.ovf));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int thr, tmo;
    // Reset state
    step(1, 1, 1, 1, 0, 0);
    after_edge();
    check("reset_irq", int'(irq_o), 0);
    check("reset_pending", int'(pending_cnt_o), 0);

    // Threshold 4, pulses at 10,12,13,15 -> irq at 16
    for (int c = 0; c <= 15; c++)
      step(0, (c == 10 || c == 12 || c == 13 || c == 15), 1, 4, 0, 0);
    after_edge();
    check("thr4_irq", int'(irq_o), 1);
    check("thr4_fired", int'(fired_cnt_o), 4);
    check("thr4_pending", int'(pending_cnt_o), 0);
    step(0, 0, 1, 4, 0, 1);

    // Threshold 8, timeout 20, single pulse at cycle 5
    step(1, 0, 1, 8, 20, 0);
    for (int c = 0; c <= 25; c++) step(0, (c == 5), 1, 8, 20, 0);
    after_edge();
    check("tmo_irq", int'(irq_o), TIMEOUT_EN ? 1 : 0);
    check("tmo_count", TIMEOUT_EN ? int'(fired_cnt_o) : int'(pending_cnt_o), 1);

    // Threshold 2: pulses in FIRE, then ack -> ACCUM with 3, then re-fire
    step(1, 0, 1, 2, 0, 0);
    step(0, 1, 1, 2, 0, 0);
    step(0, 1, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 2, 0, 0);
    step(0, 0, 1, 2, 0, 1);
    after_edge();
    check("ack_irq_low", int'(irq_o), 0);
    check("ack_pending3", int'(pending_cnt_o), 3);
    step(0, 0, 1, 2, 0, 0);
    after_edge();
    check("refire_irq", int'(irq_o), 1);
    check("refire_fired", int'(fired_cnt_o), 3);

    // Saturation with interrupts disabled
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 260; i++) step(0, 1, 0, 1, 0, 0);
    after_edge();
    check("sat_pending", int'(pending_cnt_o), 255);
    check("sat_overflow", int'(overflow_o), 1);
    check("sat_no_irq", int'(irq_o), 0);
    step(0, 0, 1, 1, 0, 0);
    after_edge();
    check("sat_fire_irq", int'(irq_o), 1);
    check("sat_fired", int'(fired_cnt_o), 255);
    step(0, 0, 1, 1, 0, 1);
    after_edge();
    check("sat_ack_ovf", int'(overflow_o), 0);

    // Threshold 1: pulse together with ack
    step(1, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 1);
    after_edge();
    check("pulse_ack_low", int'(irq_o), 0);
    step(0, 0, 1, 1, 0, 0);
    after_edge();
    check("pulse_ack_refire", int'(irq_o), 1);
    check("pulse_ack_fired", int'(fired_cnt_o), 1);

    // Reset in ACCUM with 3 pending; pulse during reset is dropped
    step(1, 0, 1, 8, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8, 0, 0);
    after_edge();
    check("accum_pending3", int'(pending_cnt_o), 3);
    step(1, 1, 1, 8, 0, 0);
    after_edge();
    check("rst_accum_pending", int'(pending_cnt_o), 0);
    check("rst_accum_irq", int'(irq_o), 0);
    step(0, 0, 1, 8, 0, 0);
    after_edge();
    check("rst_pulse_dropped", int'(pending_cnt_o), 0);

    // Random traffic; the scoreboard checks every cycle
    thr = 3; tmo = 0;
    for (int i = 0; i < 2500; i++) begin
      if (i % 60 == 0) begin
        thr = int'($urandom_range(0, 6));
        tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, 25));
      end
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 9) != 0),
           thr, tmo,
           ($urandom_range(0, 9) < 3));
    end

    step(0, 0, 0, 1, 0, 0);
    repeat (3) @(posedge clk_i);
    #3;
    check("sb_drained", exp_q.size(), 0);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
